// File: rtl/hs_pkg.sv
// Shared definitions for the bundled-data handshake endpoints.
//   HS_DATA_W_DEFAULT : default data width, common to the async pipeline stages
//   hs_rx_state_t     : receive-side handshake state
package hs_pkg;

    localparam int unsigned HS_DATA_W_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE,
        ACK_HI
    } hs_rx_state_t;

endpackage

// File: rtl/hs_sync.sv
// N-stage reset-to-0 synchronizer for a single asynchronous handshake input.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage
//   d     : asynchronous input
//   q     : synchronized output (STAGES clocks of latency)
module hs_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hs4_rx_sync.sv
// Clocked receiver for the 4-phase bundled-data handshake. Synchronizes hs_req,
// captures hs_data into a show-ahead FIFO once per handshake and returns hs_ack,
// then offers the words on a valid/ready interface.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   hs_req     : async request (synchronized before use)
//   hs_data    : bundled data, sampled only on a capture edge
//   hs_ack     : acknowledge, straight from a flop
//   m_valid    : FIFO non-empty
//   m_ready    : consumer takes head word
//   m_data     : FIFO head word
//   count      : FIFO occupancy
//   rx_total   : captured-word counter, wraps at 16 bits
module hs4_rx_sync
    import hs_pkg::*;
#(
    parameter int unsigned DATA_W      = HS_DATA_W_DEFAULT,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       hs_req,
    input  logic [DATA_W-1:0]          hs_data,
    output logic                       hs_ack,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [DATA_W-1:0]          m_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                rx_total
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic              req_s;
    hs_rx_state_t      state_q, state_d;
    logic              ack_q;
    logic              push, pop;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [15:0]       rx_total_q;

    hs_sync #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (hs_req),
        .q     (req_s)
    );

    // Capture only from IDLE, so a held request can never produce a second word.
    // The full check uses the pre-edge count; a same-cycle pop does not help.
    always_comb begin
        state_d = state_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_s && (count_q < CNT_W'(DEPTH))) begin
                    push    = 1'b1;
                    state_d = ACK_HI;
                end
            end
            ACK_HI: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = m_valid && m_ready;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ack_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rx_total_q <= '0;
        end else begin
            state_q <= state_d;
            // Dedicated flop keeps hs_ack glitch-free regardless of state encoding.
            ack_q   <= (state_d == ACK_HI);
            count_q <= count_d;
            if (push) begin
                wr_ptr_q   <= wr_ptr_q + PTR_W'(1);
                rx_total_q <= rx_total_q + 16'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= hs_data;
        end
    end

    assign hs_ack   = ack_q;
    assign m_valid  = (count_q != '0);
    assign m_data   = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign rx_total = rx_total_q;

endmodule
